// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width, line levels.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  function automatic logic frame_parity(input logic [DATA_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: one-cycle tick at the end of every CLKS_PER_BIT period.
// restart holds the count at zero so a new bit period begins on the next cycle.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  generate
    if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
      $error("uart_baud_gen: CLKS_PER_BIT must be in 1..65535");
    end

    if (CLKS_PER_BIT <= 1) begin : g_single
      // Every cycle is a full bit period, so no counter is needed.
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, restart};
      assign tick = 1'b1;
    end else begin : g_count
      localparam int CW = $clog2(CLKS_PER_BIT);
      localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;

      assign tick = (cnt_reg == LAST);

      always_comb begin
        cnt_next = cnt_reg + CW'(1);
        if (restart || tick) begin
          cnt_next = '0;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. One byte accepted per valid/ready handshake.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  generate
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  localparam logic       ODD_BIT   = (PARITY_ODD != 0);
  localparam logic       USE_PAR   = (PARITY_EN != 0);
  localparam logic [0:0] STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_t       state_reg,    state_next;
  logic [DATA_W-1:0] shift_reg,    shift_next;
  logic              parity_reg,   parity_next;
  logic [2:0]        bit_idx_reg,  bit_idx_next;
  logic [0:0]        stop_cnt_reg, stop_cnt_next;
  logic              done_reg,     done_next;
  logic              tick;
  logic              accept;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(state_reg == IDLE),
    .tick   (tick)
  );

  assign ready  = (state_reg == IDLE) && enable && !rst;
  assign accept = valid && ready;
  assign busy   = (state_reg != IDLE);
  assign done   = done_reg;

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    parity_next   = parity_reg;
    bit_idx_next  = bit_idx_reg;
    stop_cnt_next = stop_cnt_reg;
    done_next     = 1'b0;
    tx            = LINE_IDLE;

    case (state_reg)
      IDLE: begin
        tx = LINE_IDLE;
        if (accept) begin
          shift_next   = data_in;
          parity_next  = frame_parity(data_in, ODD_BIT);
          bit_idx_next = 3'd0;
          state_next   = START;
        end
      end
      START: begin
        tx = LINE_START;
        if (tick) begin
          state_next = DATA;
        end
      end
      DATA: begin
        tx = shift_reg[0];
        if (tick) begin
          shift_next = shift_reg >> 1;
          if (bit_idx_reg == 3'd7) begin
            stop_cnt_next = '0;
            state_next    = USE_PAR ? PARITY : STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      PARITY: begin
        tx = parity_reg;
        if (tick) begin
          stop_cnt_next = '0;
          state_next    = STOP;
        end
      end
      STOP: begin
        tx = LINE_STOP;
        if (tick) begin
          if (stop_cnt_reg == STOP_LAST) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            stop_cnt_next = stop_cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        tx         = LINE_IDLE;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      bit_idx_reg  <= '0;
      stop_cnt_reg <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      parity_reg   <= parity_next;
      bit_idx_reg  <= bit_idx_next;
      stop_cnt_reg <= stop_cnt_next;
      done_reg     <= done_next;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three parameterisations share clock and reset;
// each task drives one scenario and checks the serial line cycle by cycle.
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // a: defaults, b: 4 clk/bit + even parity, c: two stop bits
  logic       en_a = 1'b1, vld_a = 1'b0, rdy_a, tx_a, busy_a, done_a;
  logic [7:0] din_a = 8'h00;
  logic       en_b = 1'b1, vld_b = 1'b0, rdy_b, tx_b, busy_b, done_b;
  logic [7:0] din_b = 8'h00;
  logic       en_c = 1'b1, vld_c = 1'b0, rdy_c, tx_c, busy_c, done_c;
  logic [7:0] din_c = 8'h00;

  uart_tx dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .data_in(din_a), .valid(vld_a),
    .ready(rdy_a), .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .data_in(din_b), .valid(vld_b),
    .ready(rdy_b), .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  uart_tx #(.CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst(rst), .enable(en_c), .data_in(din_c), .valid(vld_c),
    .ready(rdy_c), .tx(tx_c), .busy(busy_c), .done(done_c)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    step();
    step();
    got = {tx_a & tx_b & tx_c, rdy_a | rdy_b | rdy_c, busy_a | busy_b | busy_c,
           done_a | done_b | done_c};
    checks++;
    if (got !== 4'b1000) begin
      errors++;
      $display("FAIL reset_outputs: {tx,ready,busy,done}=%b expected 1000", got);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({rdy_a, rdy_b, rdy_c} !== 3'b111) begin
      errors++;
      $display("FAIL ready_after_reset: %b expected 111", {rdy_a, rdy_b, rdy_c});
    end
    $display("reset released");
  endtask

  task automatic test_basic();
    logic [9:0] seq;
    seq = 10'b1101001010;  // line sequence 0,1,0,1,0,0,1,0,1,1 read from bit 0
    din_a = 8'hA5;
    vld_a = 1'b1;
    step();
    vld_a = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (tx_a !== seq[k] || busy_a !== 1'b1 || done_a !== 1'b0) begin
        errors++;
        $display("FAIL basic_bit%0d: tx=%b busy=%b done=%b expected tx=%b busy=1 done=0",
                 k, tx_a, busy_a, done_a, seq[k]);
      end
      step();
    end
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || tx_a !== 1'b1) begin
      errors++;
      $display("FAIL basic_done: done=%b busy=%b tx=%b expected 1 0 1", done_a, busy_a, tx_a);
    end
    step();
    checks++;
    if (done_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_width: done=%b expected 0", done_a);
    end
    $display("frame a: 0xA5 sent");
  endtask

  task automatic test_parity_slow();
    logic [10:0] frame;
    logic [10:0] rx_bits;
    frame   = {1'b1, 1'b1, 8'h07, 1'b0};  // stop, even parity of 0x07, data, start
    rx_bits = '0;
    din_b = 8'h07;
    vld_b = 1'b1;
    step();
    vld_b = 1'b0;
    for (int k = 0; k < 44; k++) begin
      checks++;
      if (tx_b !== frame[k / 4] || busy_b !== 1'b1) begin
        errors++;
        $display("FAIL parity_cycle%0d: tx=%b busy=%b expected tx=%b busy=1",
                 k, tx_b, busy_b, frame[k / 4]);
      end
      if (k % 4 == 2) rx_bits[k / 4] = tx_b;
      step();
    end
    checks++;
    if (rx_bits[8:1] !== 8'h07 || rx_bits[0] !== 1'b0 || rx_bits[10] !== 1'b1) begin
      errors++;
      $display("FAIL loopback_data: byte=%h start=%b stop=%b expected 07 0 1",
               rx_bits[8:1], rx_bits[0], rx_bits[10]);
    end
    checks++;
    if (rx_bits[9] !== 1'b1) begin
      errors++;
      $display("FAIL loopback_parity: parity=%b expected 1", rx_bits[9]);
    end
    checks++;
    if (done_b !== 1'b1 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL parity_done: done=%b busy=%b expected 1 0", done_b, busy_b);
    end
    step();
    $display("frame b: 0x07 sent with parity");
  endtask

  task automatic test_back_to_back();
    logic [10:0] f0;
    logic [10:0] f1;
    f0 = {2'b11, 8'h00, 1'b0};
    f1 = {2'b11, 8'hFF, 1'b0};
    din_c = 8'h00;
    vld_c = 1'b1;
    step();
    din_c = 8'hFF;  // next request waits, valid held
    for (int k = 0; k < 11; k++) begin
      checks++;
      if (tx_c !== f0[k] || busy_c !== 1'b1) begin
        errors++;
        $display("FAIL b2b_f0_bit%0d: tx=%b busy=%b expected tx=%b busy=1",
                 k, tx_c, busy_c, f0[k]);
      end
      step();
    end
    checks++;
    if (done_c !== 1'b1 || rdy_c !== 1'b1 || tx_c !== 1'b1) begin
      errors++;
      $display("FAIL b2b_handover: done=%b ready=%b tx=%b expected 1 1 1", done_c, rdy_c, tx_c);
    end
    step();
    vld_c = 1'b0;
    for (int k = 0; k < 11; k++) begin
      checks++;
      if (tx_c !== f1[k] || busy_c !== 1'b1) begin
        errors++;
        $display("FAIL b2b_f1_bit%0d: tx=%b busy=%b expected tx=%b busy=1",
                 k, tx_c, busy_c, f1[k]);
      end
      step();
    end
    checks++;
    if (done_c !== 1'b1 || busy_c !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: done=%b busy=%b expected 1 0", done_c, busy_c);
    end
    step();
    $display("frames c: 0x00 then 0xFF sent back to back");
  endtask

  task automatic test_ignore_requests();
    logic [9:0] frame;
    frame = {1'b1, 8'h96, 1'b0};
    din_a = 8'h96;
    vld_a = 1'b1;
    step();
    vld_a = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (tx_a !== frame[k]) begin
        errors++;
        $display("FAIL midframe_bit%0d: tx=%b expected %b", k, tx_a, frame[k]);
      end
      vld_a = (k == 3);
      din_a = (k == 3) ? 8'h3C : 8'h96;
      if (k == 3) begin
        checks++;
        if (rdy_a !== 1'b0) begin
          errors++;
          $display("FAIL midframe_ready: ready=%b expected 0", rdy_a);
        end
      end
      step();
    end
    vld_a = 1'b0;
    checks++;
    if (done_a !== 1'b1) begin
      errors++;
      $display("FAIL midframe_done: done=%b expected 1", done_a);
    end
    en_a  = 1'b0;
    vld_a = 1'b1;
    din_a = 8'h3C;
    #1;
    checks++;
    if (rdy_a !== 1'b0) begin
      errors++;
      $display("FAIL disabled_ready: ready=%b expected 0", rdy_a);
    end
    for (int k = 0; k < 12; k++) begin
      step();
      checks++;
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
        errors++;
        $display("FAIL disabled_idle%0d: tx=%b busy=%b done=%b expected 1 0 0",
                 k, tx_a, busy_a, done_a);
      end
    end
    vld_a = 1'b0;
    en_a  = 1'b1;
    $display("frame a: 0x96 sent, 0x3C requests ignored");
  endtask

  task automatic test_reset_midframe();
    logic [9:0] frame;
    frame = {1'b1, 8'h81, 1'b0};
    din_a = 8'h81;
    vld_a = 1'b1;
    step();
    vld_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (tx_a !== frame[k]) begin
        errors++;
        $display("FAIL abort_bit%0d: tx=%b expected %b", k, tx_a, frame[k]);
      end
      if (k < 4) step();
    end
    // now on data bit 3: reset with a request present
    rst   = 1'b1;
    vld_a = 1'b1;
    din_a = 8'h55;
    step();
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 || rdy_a !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: tx=%b busy=%b done=%b ready=%b expected 1 0 0 0",
               tx_a, busy_a, done_a, rdy_a);
    end
    rst   = 1'b0;
    vld_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (busy_a !== 1'b0 || done_a !== 1'b0 || tx_a !== 1'b1) begin
        errors++;
        $display("FAIL abort_quiet%0d: busy=%b done=%b tx=%b expected 0 0 1",
                 k, busy_a, done_a, tx_a);
      end
    end
    frame = {1'b1, 8'h55, 1'b0};
    vld_a = 1'b1;
    step();
    vld_a = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (tx_a !== frame[k]) begin
        errors++;
        $display("FAIL after_abort_bit%0d: tx=%b expected %b", k, tx_a, frame[k]);
      end
      step();
    end
    checks++;
    if (done_a !== 1'b1) begin
      errors++;
      $display("FAIL after_abort_done: done=%b expected 1", done_a);
    end
    step();
    $display("frame a: 0x81 aborted by reset, 0x55 sent");
  endtask

  task automatic test_enable_drop();
    logic [9:0] frame;
    frame = {1'b1, 8'hC3, 1'b0};
    din_a = 8'hC3;
    vld_a = 1'b1;
    step();
    vld_a = 1'b0;
    en_a  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (tx_a !== frame[k] || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL endrop_bit%0d: tx=%b busy=%b expected tx=%b busy=1",
                 k, tx_a, busy_a, frame[k]);
      end
      step();
    end
    checks++;
    if (done_a !== 1'b1 || rdy_a !== 1'b0) begin
      errors++;
      $display("FAIL endrop_done: done=%b ready=%b expected 1 0", done_a, rdy_a);
    end
    vld_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (rdy_a !== 1'b0 || tx_a !== 1'b1 || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL endrop_idle%0d: ready=%b tx=%b busy=%b expected 0 1 0",
                 k, rdy_a, tx_a, busy_a);
      end
    end
    vld_a = 1'b0;
    $display("frame a: 0xC3 sent with enable dropped");
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_parity_slow();
    test_back_to_back();
    test_ignore_requests();
    test_reset_midframe();
    test_enable_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
